// File: rtl/coin_disp.sv
// Coin refund dispenser: greedy 1 Rs / 50 p / 25 p selection with a handshake per coin.
// Define COIN_STOCK_EN to add finite stock counters, restock_in and shortfall reporting.
module coin_disp #(
    parameter logic [3:0] STOCK25  = 4'd8,
    parameter logic [3:0] STOCK50  = 4'd8,
    parameter logic [3:0] STOCK100 = 4'd8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_in,
    input  logic [3:0] amount_in,
    input  logic       coin_ack_in,
    input  logic       restock_in,
    output logic [1:0] coin_out,
    output logic       coin_valid_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       error_out,
    output logic [3:0] remaining_out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SELECT  = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] FINISH  = 2'd3;

    localparam logic [1:0] COIN25  = 2'b00;
    localparam logic [1:0] COIN50  = 2'b01;
    localparam logic [1:0] COIN100 = 2'b10;
    localparam logic [1:0] NO_COIN = 2'b11;

    logic [1:0] state_reg, state_next;
    logic [3:0] remaining_reg, remaining_next;
    logic [1:0] coin_reg, coin_next;
    logic       error_reg, error_next;
    logic [2:0] stock_avail;
    logic       ack_take;

    assign ack_take = (state_reg == PRESENT) && coin_ack_in;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            COIN100: coin_value = 4'd4;
            COIN50:  coin_value = 4'd2;
            default: coin_value = 4'd1;
        endcase
    endfunction

`ifdef COIN_STOCK_EN
    // One counter per coin kind, indexed by coin code; an acknowledge beats a restock.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stock
            localparam logic [3:0] INIT = (gi == 0) ? STOCK25 :
                                          (gi == 1) ? STOCK50 : STOCK100;
            logic [3:0] count_reg;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    count_reg <= INIT;
                end else if (ack_take && (coin_reg == 2'(gi))) begin
                    if (count_reg != 4'd0)
                        count_reg <= count_reg - 4'd1;
                end else if ((state_reg == IDLE) && restock_in) begin
                    count_reg <= INIT;
                end
            end

            assign stock_avail[gi] = (count_reg != 4'd0);
        end
    endgenerate
`else
    logic unused_cfg;
    assign unused_cfg  = ^{restock_in, STOCK25, STOCK50, STOCK100};
    assign stock_avail = 3'b111;
`endif

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        coin_next      = coin_reg;
        error_next     = error_reg;
        case (state_reg)
            IDLE: begin
                if (start_in) begin
                    error_next     = 1'b0;
                    remaining_next = amount_in;
                    state_next     = (amount_in != 4'd0) ? SELECT : FINISH;
                end
            end
            SELECT: begin
                if ((remaining_reg >= 4'd4) && stock_avail[2]) begin
                    coin_next  = COIN100;
                    state_next = PRESENT;
                end else if ((remaining_reg >= 4'd2) && stock_avail[1]) begin
                    coin_next  = COIN50;
                    state_next = PRESENT;
                end else if (stock_avail[0]) begin
                    coin_next  = COIN25;
                    state_next = PRESENT;
                end else begin
                    // Shortfall: remaining keeps the undispensed amount.
                    error_next = 1'b1;
                    state_next = FINISH;
                end
            end
            PRESENT: begin
                if (coin_ack_in) begin
                    remaining_next = remaining_reg - coin_value(coin_reg);
                    state_next     = (remaining_next == 4'd0) ? FINISH : SELECT;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            remaining_reg <= 4'd0;
            coin_reg      <= NO_COIN;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            coin_reg      <= coin_next;
            error_reg     <= error_next;
        end
    end

    // Outputs decode straight from registers so reset takes effect without a clock edge.
    assign coin_valid_out = (state_reg == PRESENT);
    assign coin_out       = (state_reg == PRESENT) ? coin_reg : NO_COIN;
    assign busy_out       = (state_reg != IDLE);
    assign done_out       = (state_reg == FINISH);
    assign error_out      = error_reg;
    assign remaining_out  = remaining_reg;

endmodule

// File: tb/tb_coin_disp.sv
// Directed bench for coin_disp: a vector table of refunds plus hand-written stock and reset sequences.
// Stock-specific sequences run only when COIN_STOCK_EN is defined.
module tb_coin_disp;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start_in = 1'b0;
    logic [3:0] amount_in = 4'd0;
    logic       coin_ack_in = 1'b0;
    logic       restock_in = 1'b0;
    int         sel = 0;

    logic [1:0] coin_a, coin_o;
    logic       valid_a, busy_a, done_a, err_a;
    logic       valid_o, busy_o, done_o, err_o;
    logic [3:0] rem_a, rem_o;
    logic       start_a;

    int errors = 0;
    int checks = 0;
    int txn = 0;

    assign start_a = start_in && (sel == 0);

    coin_disp u_dut (
        .clock(clock), .reset(reset), .start_in(start_a), .amount_in(amount_in),
        .coin_ack_in(coin_ack_in), .restock_in(restock_in), .coin_out(coin_a),
        .coin_valid_out(valid_a), .busy_out(busy_a), .done_out(done_a),
        .error_out(err_a), .remaining_out(rem_a)
    );

`ifdef COIN_STOCK_EN
    logic [1:0] coin_b, coin_z;
    logic       valid_b, busy_b, done_b, err_b, valid_z, busy_z, done_z, err_z;
    logic [3:0] rem_b, rem_z;
    logic       start_b, start_z;

    assign start_b = start_in && (sel == 1);
    assign start_z = start_in && (sel == 2);

    coin_disp #(.STOCK25(4'd8), .STOCK50(4'd8), .STOCK100(4'd1)) u_dut_b (
        .clock(clock), .reset(reset), .start_in(start_b), .amount_in(amount_in),
        .coin_ack_in(coin_ack_in), .restock_in(restock_in), .coin_out(coin_b),
        .coin_valid_out(valid_b), .busy_out(busy_b), .done_out(done_b),
        .error_out(err_b), .remaining_out(rem_b)
    );

    coin_disp #(.STOCK25(4'd0), .STOCK50(4'd0), .STOCK100(4'd0)) u_dut_z (
        .clock(clock), .reset(reset), .start_in(start_z), .amount_in(amount_in),
        .coin_ack_in(coin_ack_in), .restock_in(restock_in), .coin_out(coin_z),
        .coin_valid_out(valid_z), .busy_out(busy_z), .done_out(done_z),
        .error_out(err_z), .remaining_out(rem_z)
    );

    always_comb begin
        case (sel)
            1: {coin_o, valid_o, busy_o, done_o, err_o, rem_o} = {coin_b, valid_b, busy_b, done_b, err_b, rem_b};
            2: {coin_o, valid_o, busy_o, done_o, err_o, rem_o} = {coin_z, valid_z, busy_z, done_z, err_z, rem_z};
            default: {coin_o, valid_o, busy_o, done_o, err_o, rem_o} = {coin_a, valid_a, busy_a, done_a, err_a, rem_a};
        endcase
    end
`else
    always_comb begin
        {coin_o, valid_o, busy_o, done_o, err_o, rem_o} = {coin_a, valid_a, busy_a, done_a, err_a, rem_a};
    end
`endif

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] amt;
        int         dly;
        bit         noise;
        int         ncoin;
        logic [9:0] coins;
        logic       err;
        logic [3:0] rem;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issues one refund and plays the coin mechanism; coin i lands in coins[2i+1:2i].
    task automatic run_refund(input logic [3:0] amt, input int dly, input bit noise,
                              output logic [9:0] coins, output int ncoin, output int done_at,
                              output int first_valid, output logic [3:0] rem_at_done,
                              output logic err_at_done);
        int  cnt;
        bit  prev_valid;
        logic [1:0] held;
        coins = '1; ncoin = 0; done_at = -1; first_valid = -1;
        prev_valid = 1'b0; cnt = 0; held = 2'b11;
        rem_at_done = 4'hx; err_at_done = 1'bx;
        @(negedge clock);
        start_in = 1'b1;
        amount_in = amt;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clock);
            start_in  = noise;
            amount_in = noise ? 4'd9 : amt;
            if (done_o) begin
                done_at = cyc; rem_at_done = rem_o; err_at_done = err_o;
                start_in = 1'b0; coin_ack_in = 1'b0;
                break;
            end
            if (valid_o) begin
                if (!prev_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    held = coin_o;
                    if (ncoin < 5) coins[2*ncoin +: 2] = coin_o;
                    ncoin++;
                    cnt = 0;
                end else begin
                    check("coin_stable", 32'(coin_o), 32'(held));
                end
                coin_ack_in = (cnt >= dly);
                cnt++;
            end else begin
                coin_ack_in = 1'b0;
            end
            prev_valid = valid_o;
        end
        start_in = 1'b0;
        coin_ack_in = 1'b0;
        if (done_at < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done_out expected done_out within 80 cycles");
        end
        txn++;
        $display("txn %0d sel=%0d amount=%0d coins=%b ncoin=%0d done_at=%0d rem=%0d err=%0d",
                 txn, sel, amt, coins, ncoin, done_at, rem_at_done, err_at_done);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_coin"},  32'(coin_o),  32'd3);
        check({tag, "_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o),  32'd0);
        check({tag, "_done"},  32'(done_o),  32'd0);
        check({tag, "_err"},   32'(err_o),   32'd0);
        check({tag, "_rem"},   32'(rem_o),   32'd0);
    endtask

    initial begin
        logic [9:0] coins;
        int ncoin, done_at, first_valid, exp_done;
        logic [3:0] rem_d;
        logic err_d;

        vecs[0] = '{4'd7,  0, 1'b0, 3, 10'b11_11_00_01_10, 1'b0, 4'd0};
        vecs[1] = '{4'd2,  5, 1'b0, 1, 10'b11_11_11_11_01, 1'b0, 4'd0};
        vecs[2] = '{4'd0,  0, 1'b0, 0, 10'b11_11_11_11_11, 1'b0, 4'd0};
        vecs[3] = '{4'd1,  0, 1'b1, 1, 10'b11_11_11_11_00, 1'b0, 4'd0};
        vecs[4] = '{4'd15, 0, 1'b0, 5, 10'b00_01_10_10_10, 1'b0, 4'd0};
        vecs[5] = '{4'd6,  1, 1'b0, 2, 10'b11_11_11_01_10, 1'b0, 4'd0};
        vecs[6] = '{4'd3,  0, 1'b0, 2, 10'b11_11_11_00_01, 1'b0, 4'd0};

        @(negedge clock);
        @(negedge clock);
        check_reset_outputs("reset_init");
        reset = 1'b1;
        @(negedge clock);

        sel = 0;
        for (int i = 0; i < 7; i++) begin
            run_refund(vecs[i].amt, vecs[i].dly, vecs[i].noise, coins, ncoin, done_at, first_valid, rem_d, err_d);
            exp_done = (vecs[i].ncoin == 0) ? ((vecs[i].amt == 4'd0) ? 1 : 2)
                                            : vecs[i].ncoin * (2 + vecs[i].dly) + 1;
            check($sformatf("v%0d_ncoin", i), ncoin, vecs[i].ncoin);
            check($sformatf("v%0d_coins", i), 32'(coins), 32'(vecs[i].coins));
            check($sformatf("v%0d_done_at", i), done_at, exp_done);
            check($sformatf("v%0d_first_valid", i), first_valid, (vecs[i].ncoin > 0) ? 2 : -1);
            check($sformatf("v%0d_err", i), 32'(err_d), 32'(vecs[i].err));
            check($sformatf("v%0d_rem", i), 32'(rem_d), 32'(vecs[i].rem));
            @(negedge clock);
            check($sformatf("v%0d_idle_busy", i), 32'(busy_o), 32'd0);
            check($sformatf("v%0d_done_pulse", i), 32'(done_o), 32'd0);
        end

`ifdef COIN_STOCK_EN
        // One 1-Rupee coin in stock: second refund of 4 must fall back to two 50 p coins.
        sel = 1;
        run_refund(4'd4, 0, 1'b0, coins, ncoin, done_at, first_valid, rem_d, err_d);
        check("stk100_first_coins", 32'(coins), 32'(10'b11_11_11_11_10));
        check("stk100_first_ncoin", ncoin, 1);
        run_refund(4'd4, 0, 1'b0, coins, ncoin, done_at, first_valid, rem_d, err_d);
        check("stk100_second_coins", 32'(coins), 32'(10'b11_11_11_01_01));
        check("stk100_second_done", done_at, 5);
        check("stk100_second_err", 32'(err_d), 32'd0);

        // Empty dispenser: shortfall keeps the undispensed amount and flags error.
        sel = 2;
        run_refund(4'd3, 0, 1'b0, coins, ncoin, done_at, first_valid, rem_d, err_d);
        check("empty_ncoin", ncoin, 0);
        check("empty_err", 32'(err_d), 32'd1);
        check("empty_rem", 32'(rem_d), 32'd3);
        check("empty_done_at", done_at, 2);
        @(negedge clock);
        check("empty_err_hold", 32'(err_o), 32'd1);
        run_refund(4'd0, 0, 1'b0, coins, ncoin, done_at, first_valid, rem_d, err_d);
        check("empty_err_cleared", 32'(err_d), 32'd0);
        check("empty_zero_done_at", done_at, 1);
        sel = 1;
`else
        run_refund(4'd4, 0, 1'b0, coins, ncoin, done_at, first_valid, rem_d, err_d);
        check("unlim_first_coins", 32'(coins), 32'(10'b11_11_11_11_10));
        run_refund(4'd4, 0, 1'b0, coins, ncoin, done_at, first_valid, rem_d, err_d);
        check("unlim_second_coins", 32'(coins), 32'(10'b11_11_11_11_10));
        check("unlim_second_err", 32'(err_d), 32'd0);
        sel = 0;
`endif

        // Reset asserted between clock edges while a coin is presented.
        @(negedge clock);
        start_in = 1'b1;
        amount_in = 4'd2;
        @(negedge clock);
        start_in = 1'b0;
        @(negedge clock);
        check("pre_reset_valid", 32'(valid_o), 32'd1);
        check("pre_reset_rem", 32'(rem_o), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_refund(4'd1, 0, 1'b0, coins, ncoin, done_at, first_valid, rem_d, err_d);
        check("post_reset_coin", 32'(coins), 32'(10'b11_11_11_11_00));
        check("post_reset_done", done_at, 3);
        run_refund(4'd4, 0, 1'b0, coins, ncoin, done_at, first_valid, rem_d, err_d);
        check("post_reset_stock_reload", 32'(coins), 32'(10'b11_11_11_11_10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
